// File: rtl/cphy_lp_pkg.sv
// Shared C-PHY LP definitions: contention monitor state encoding and counter widths.
package cphy_lp_pkg;

  // Filter threshold range 1..15 and holdoff range 1..255 set these widths.
  localparam int unsigned FILTER_W    = 4;
  localparam int unsigned HOLDOFF_W   = 8;
  localparam int unsigned ERR_COUNT_W = 8;

  typedef logic [1:0] contention_state_t;

  localparam contention_state_t IDLE    = 2'd0;
  localparam contention_state_t SETTLE  = 2'd1;
  localparam contention_state_t MONITOR = 2'd2;
  localparam contention_state_t ERROR   = 2'd3;

endpackage

// File: rtl/contention_filter.sv
// Saturating consecutive-high counter for one raw contention flag.
// hit is combinational: it is high on the edge where the counter would reach THRESHOLD.
module contention_filter
  import cphy_lp_pkg::*;
#(
  parameter int unsigned THRESHOLD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_en,
  input  logic flag,
  output logic hit
);

  localparam logic [FILTER_W-1:0] THR    = FILTER_W'(THRESHOLD);
  localparam logic [FILTER_W-1:0] THR_M1 = FILTER_W'(THRESHOLD - 1);

  logic [FILTER_W-1:0] count;

  // Count consecutive high samples; any low sample or disabled sampling clears.
  always_ff @(posedge clk) begin
    if (rst || !sample_en || !flag) begin
      count <= '0;
    end else if (count != THR) begin
      count <= count + 1'b1;
    end
  end

  assign hit = sample_en && flag && (count >= THR_M1);

endmodule

// File: rtl/contention_monitor.sv
// LP contention qualifier: masks driver settling after LpTxEn, filters raw
// detector flags, and on qualified contention forces LP drivers off, latches
// sticky flags and pulses an interrupt.
// Optional macro CONTENTION_ERR_COUNT_EN adds the saturating ContentionErrCount output.
module contention_monitor
  import cphy_lp_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES  = 4,
  parameter int unsigned HOLDOFF_CYCLES = 8
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   ErrContentionP0,
  input  logic                   ErrContentionP1,
  input  logic                   LpTxEn,
  input  logic                   ErrClear,
  output logic                   LpTxForceOff,
  output logic                   ErrContentionLp0,
  output logic                   ErrContentionLp1,
  output logic                   ContentionIrq
`ifdef CONTENTION_ERR_COUNT_EN
  ,
  output logic [ERR_COUNT_W-1:0] ContentionErrCount
`endif
);

  localparam logic [HOLDOFF_W-1:0] HOLD_LAST = HOLDOFF_W'(HOLDOFF_CYCLES - 1);

  contention_state_t    state;
  logic [HOLDOFF_W-1:0] hold_cnt;
  logic                 sample_en;
  logic                 hit0;
  logic                 hit1;
  logic                 err_entry;

  // Filters only sample in MONITOR with the transmitter still enabled, so an
  // enable drop both clears the counters and suppresses a same-edge threshold hit.
  assign sample_en = (state == MONITOR) && LpTxEn;
  assign err_entry = sample_en && (hit0 || hit1);

  contention_filter #(.THRESHOLD(FILTER_CYCLES)) u_filter_p0 (
    .clk       (Clk),
    .rst       (Rst),
    .sample_en (sample_en),
    .flag      (ErrContentionP0),
    .hit       (hit0)
  );

  contention_filter #(.THRESHOLD(FILTER_CYCLES)) u_filter_p1 (
    .clk       (Clk),
    .rst       (Rst),
    .sample_en (sample_en),
    .flag      (ErrContentionP1),
    .hit       (hit1)
  );

  // State sequencing, holdoff timing and registered reaction outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state            <= IDLE;
      hold_cnt         <= '0;
      LpTxForceOff     <= 1'b0;
      ErrContentionLp0 <= 1'b0;
      ErrContentionLp1 <= 1'b0;
      ContentionIrq    <= 1'b0;
    end else begin
      ContentionIrq <= 1'b0;
      case (state)
        IDLE: begin
          hold_cnt <= '0;
          if (LpTxEn) begin
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (!LpTxEn) begin
            state    <= IDLE;
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state    <= MONITOR;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        MONITOR: begin
          if (!LpTxEn) begin
            state <= IDLE;
          end else if (err_entry) begin
            state            <= ERROR;
            LpTxForceOff     <= 1'b1;
            ErrContentionLp0 <= hit0;
            ErrContentionLp1 <= hit1;
            ContentionIrq    <= 1'b1;
          end
        end
        ERROR: begin
          if (ErrClear && !LpTxEn) begin
            state            <= IDLE;
            LpTxForceOff     <= 1'b0;
            ErrContentionLp0 <= 1'b0;
            ErrContentionLp1 <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CONTENTION_ERR_COUNT_EN
  // Lifetime count of ERROR entries; saturates and clears only on reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ContentionErrCount <= '0;
    end else if (err_entry && (ContentionErrCount != '1)) begin
      ContentionErrCount <= ContentionErrCount + 1'b1;
    end
  end
`else
  // No error counter in this build.
`endif

endmodule

// File: tb/tb_contention_monitor.sv
// Self-checking bench for contention_monitor (FILTER_CYCLES=4, HOLDOFF_CYCLES=8).
module tb_contention_monitor;

  logic Clk = 1'b0;
  logic Rst;
  logic ErrContentionP0;
  logic ErrContentionP1;
  logic LpTxEn;
  logic ErrClear;
  logic LpTxForceOff;
  logic ErrContentionLp0;
  logic ErrContentionLp1;
  logic ContentionIrq;
`ifdef CONTENTION_ERR_COUNT_EN
  logic [7:0] ContentionErrCount;
  int unsigned exp_cnt = 0;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  contention_monitor #(.FILTER_CYCLES(4), .HOLDOFF_CYCLES(8)) dut (
    .Clk              (Clk),
    .Rst              (Rst),
    .ErrContentionP0  (ErrContentionP0),
    .ErrContentionP1  (ErrContentionP1),
    .LpTxEn           (LpTxEn),
    .ErrClear         (ErrClear),
    .LpTxForceOff     (LpTxForceOff),
    .ErrContentionLp0 (ErrContentionLp0),
    .ErrContentionLp1 (ErrContentionLp1),
    .ContentionIrq    (ContentionIrq)
`ifdef CONTENTION_ERR_COUNT_EN
    ,
    .ContentionErrCount (ContentionErrCount)
`endif
  );

  // exp = {LpTxForceOff, ErrContentionLp0, ErrContentionLp1, ContentionIrq}
  typedef struct {
    logic       rst;
    logic       en;
    logic       p0;
    logic       p1;
    logic       clr;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[$];
  logic [3:0] outs;
  assign outs = {LpTxForceOff, ErrContentionLp0, ErrContentionLp1, ContentionIrq};

  function automatic void add(input logic rst, input logic en, input logic p0,
                              input logic p1, input logic clr, input logic [3:0] exp);
    vec_t r;
    r.rst = rst; r.en = en; r.p0 = p0; r.p1 = p1; r.clr = clr; r.exp = exp;
    tbl.push_back(r);
  endfunction

  function automatic void add_n(input int n, input logic en, input logic p0,
                                input logic p1, input logic clr, input logic [3:0] exp);
    for (int i = 0; i < n; i++) add(1'b0, en, p0, p1, clr, exp);
  endfunction

  task automatic drive(input logic rst, input logic en, input logic p0,
                       input logic p1, input logic clr);
    Rst = rst; LpTxEn = en; ErrContentionP0 = p0; ErrContentionP1 = p1; ErrClear = clr;
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  initial begin
    int edge_idx;
    Rst = 1'b1; LpTxEn = 1'b0; ErrContentionP0 = 1'b0; ErrContentionP1 = 1'b0; ErrClear = 1'b0;

    // Reset and idle behaviour
    add(1'b1, 0, 0, 0, 0, 4'b0000);
    add_n(1, 0, 0, 0, 1, 4'b0000);                  // ErrClear in IDLE: no effect
    // Holdoff masking: P0 high during the 8 SETTLE samples is ignored
    add_n(8, 1, 1, 0, 0, 4'b0000);
    add_n(1, 1, 0, 0, 0, 4'b0000);                  // SETTLE -> MONITOR edge
    add_n(3, 1, 0, 0, 0, 4'b0000);
    // Filter: 3 high, 1 low, 3 high -> no error
    add_n(3, 1, 0, 1, 0, 4'b0000);
    add_n(1, 1, 0, 0, 0, 4'b0000);
    add_n(3, 1, 0, 1, 0, 4'b0000);
    add_n(1, 1, 0, 0, 0, 4'b0000);
    // Filter: 4 high -> ERROR on 4th sample edge
    add_n(3, 1, 0, 1, 0, 4'b0000);
    add_n(1, 1, 0, 1, 0, 4'b1011);
    add_n(1, 1, 1, 1, 0, 4'b1010);                  // raw flags ignored in ERROR
    add_n(1, 1, 0, 0, 1, 4'b1010);                  // clear with enable high ignored
    add_n(1, 0, 0, 0, 0, 4'b1010);                  // enable low without clear: hold
    add_n(1, 0, 0, 0, 1, 4'b0000);                  // clear handshake
    add_n(1, 0, 0, 0, 0, 4'b0000);
    // Simultaneous polarities
    add_n(9, 1, 0, 0, 0, 4'b0000);
    add_n(3, 1, 1, 1, 0, 4'b0000);
    add_n(1, 1, 1, 1, 0, 4'b1111);
    add_n(1, 1, 0, 0, 0, 4'b1110);
    add_n(1, 0, 0, 0, 1, 4'b0000);
    // Enable drop on the would-be 4th sample
    add_n(9, 1, 0, 0, 0, 4'b0000);
    add_n(3, 1, 1, 0, 0, 4'b0000);
    add_n(1, 0, 1, 0, 0, 4'b0000);
    add_n(2, 0, 1, 0, 0, 4'b0000);
    // Re-enable: counters restart from 0, P0 needs 4 fresh samples
    add_n(9, 1, 0, 0, 0, 4'b0000);
    add_n(3, 1, 1, 0, 0, 4'b0000);
    add_n(1, 1, 1, 0, 0, 4'b1101);
    add_n(1, 0, 0, 0, 1, 4'b0000);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].en, tbl[i].p0, tbl[i].p1, tbl[i].clr);
      check($sformatf("vec%0d outs{force,lp0,lp1,irq}", i), int'(outs), int'(tbl[i].exp));
`ifdef CONTENTION_ERR_COUNT_EN
      if (tbl[i].rst) exp_cnt = 0;
      else if (tbl[i].exp[0]) exp_cnt++;
      check($sformatf("vec%0d err_count", i), int'(ContentionErrCount), int'(exp_cnt));
`endif
    end

    // Latency: enable and P0 held high from the same edge; ERROR visible after edge e12
    edge_idx = -1;
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      if (LpTxForceOff) begin
        edge_idx = i;
        break;
      end
    end
    check("latency_edge", edge_idx, 12);
    check("latency_outs", int'(outs), 4'hD);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("irq_one_cycle", int'(outs), 4'hC);

    // Reset mid-ERROR, then verify the FSM restarted from IDLE (full holdoff again)
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("reset_mid_error", int'(outs), 0);
`ifdef CONTENTION_ERR_COUNT_EN
    check("reset_err_count", int'(ContentionErrCount), 0);
`endif
    edge_idx = -1;
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      if (LpTxForceOff) begin
        edge_idx = i;
        break;
      end
    end
    check("post_reset_latency", edge_idx, 12);
`ifdef CONTENTION_ERR_COUNT_EN
    check("post_reset_err_count", int'(ContentionErrCount), 1);
`endif
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("final_clear", int'(outs), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
